alu_arbiter: RTL
================

# alu_arbiter

Round-robin arbiter that shares the single combinational 32-bit ALU between two requesters, for example the EX stage and a branch/address unit. Each requester presents one operation with a valid/ready handshake. The block latches the operands, drives the ALU for exactly one cycle, registers the result and zero flag, and returns them on a per-requester response handshake with backpressure. It sits between the requesters and the ALU instance and is the only driver of the ALU inputs.

## Interface
- BITS, 32, datapath width (operands, result)
- CBITS, 4, ALU control width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- req0_valid / req1_valid  in  1  requester N presents an operation
- req0_ready / req1_ready  out  1  operation accepted this cycle
- req0_first, req0_second / req1_first, req1_second  in  BITS  operands
- req0_control / req1_control  in  CBITS  ALU control code
- rsp0_valid / rsp1_valid  out  1  response available for requester N
- rsp0_ready / rsp1_ready  in  1  requester N consumes the response
- rsp_result  out  BITS  registered ALU result (shared by both response ports)
- rsp_zero  out  1  registered ALU zero flag
- rsp_illegal  out  1  the control code was not a supported operation
- alu_first, alu_second  out  BITS  to the ALU operand inputs
- alu_control  out  CBITS  to the ALU control input
- alu_result  in  BITS  from the ALU
- alu_zero  in  1  from the ALU
- busy  out  1  high in any state other than IDLE

## Operation
- Supported codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (unsigned compare), 1100 NOR. Every other code is illegal.
- FSM states: IDLE, EXEC, RESP.
- IDLE
  - If exactly one reqN_valid is high, grant N.
  - If both are high, grant the requester other than `last` (the requester most recently served).
  - Assert the granted reqN_ready combinationally. The other ready stays 0.
  - Latch first, second and control into the op registers, record the grant, and go to EXEC.
  - If no request is valid, stay in IDLE.
- EXEC
  - alu_* are driven from the op registers. They always reflect the op registers and are never driven combinationally from req_*.
  - Capture into the result registers:
    - Legal code: rsp_result←alu_result, rsp_zero←alu_zero, rsp_illegal←0.
    - Illegal code: rsp_result←0, rsp_zero←0, rsp_illegal←1. The ALU output is ignored because the ALU holds its previous value on unknown codes.
  - Go to RESP.
- RESP
  - rspG_valid=1 for the granted requester only.
  - rsp_result, rsp_zero and rsp_illegal are held stable.
  - When rspG_ready=1: set `last`←G and go to IDLE.
  - Otherwise stay in RESP (backpressure, no timeout).
- Requests arriving outside IDLE see ready=0. They must hold valid and their operands until accepted.
- There is at most one outstanding operation in the block.

## Timing
- Reset values: state=IDLE, last=1 (so req0 wins the first tie), op registers=0 (alu_control=0000, AND of 0,0), rsp_result=0, rsp_zero=0, rsp_illegal=0, busy=0.
- req*_ready and rsp*_valid are forced to 0 in any cycle where reset is high.
- Latency: acceptance at edge T (valid&&ready sampled). EXEC occupies cycle T+1. rsp_valid is high from cycle T+2.
- The minimum issue interval is 3 cycles, because the earliest next acceptance is in the cycle after the response handshake.
- A new request may be accepted in the cycle immediately after the response handshake completes. Same-cycle response and new acceptance is not supported.
- If reset is asserted mid-operation (EXEC or RESP), the pending operation is dropped, no response is produced, and all registers take their reset values.
- reqN_valid deasserting while in EXEC or RESP has no effect on the operation in flight.
- Arithmetic: ADD and SUB wrap modulo 2^BITS. There is no carry or overflow output.

## Test plan
- Single ADD from req0: first=5, second=7, code 0010, rsp0_ready=1 → ready0 in cycle 0, rsp0_valid in cycle 2, rsp_result=12, rsp_zero=0, rsp1_valid never asserted.
- Simultaneous requests after reset: req0 SUB 9-9, req1 OR 0xF0|0x0F, both held valid → req0 served first (result 0, zero=1), then req1 (result 0xFF). Repeat with both valid continuously → grants alternate 0,1,0,1.
- Backpressure: req1 SLT 3<8, rsp1_ready=0 for 5 cycles → rsp1_valid stays high with result=1 held constant, req0_valid=1 sees ready0=0 throughout, and req0 is accepted the cycle after rsp1_ready rises.
- Illegal code 1111 from req0 → rsp_illegal=1, rsp_result=0, rsp_zero=0. A following legal ADD returns rsp_illegal=0.
- Wrap-around: ADD 0xFFFFFFFF+1 → result 0, zero=1. SUB 0-1 → result 0xFFFFFFFF.
- Reset asserted in the EXEC cycle of a NOR → no rsp_valid, all outputs at reset values the next cycle, and a new request is accepted normally afterward with req0 winning the tie.

Source files
------------

// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
// alu_arbiter
// Round-robin arbiter sharing one combinational ALU between two requesters.
// An accepted operation is latched into op registers, presented to the ALU
// for one cycle (EXEC), and the registered result is returned on the
// granted requester's response handshake (RESP), with backpressure.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   reqN_valid/ready           operation handshake, N = 0/1
//   reqN_first/second/control  operands and ALU control code
//   rspN_valid/ready           response handshake, N = 0/1
//   rsp_result/zero/illegal    registered response payload (shared)
//   alu_first/second/control   to the ALU, driven only from op registers
//   alu_result/zero            from the ALU
//   busy                       high whenever the FSM is not IDLE
module alu_arbiter #(
  parameter int BITS  = 32,
  parameter int CBITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [BITS-1:0]  req0_first,
  input  logic [BITS-1:0]  req0_second,
  input  logic [CBITS-1:0] req0_control,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [BITS-1:0]  req1_first,
  input  logic [BITS-1:0]  req1_second,
  input  logic [CBITS-1:0] req1_control,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [BITS-1:0]  rsp_result,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output logic [BITS-1:0]  alu_first,
  output logic [BITS-1:0]  alu_second,
  output logic [CBITS-1:0] alu_control,
  input  logic [BITS-1:0]  alu_result,
  input  logic             alu_zero,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             last;       // requester most recently served
  logic             grant;      // requester owning the operation in flight
  logic             sel;        // requester that would be granted in IDLE
  logic             any_valid;
  logic             rsp_done;   // granted requester consumes the response
  logic [BITS-1:0]  op_first;
  logic [BITS-1:0]  op_second;
  logic [CBITS-1:0] op_control;

  // Only the codes the ALU actually implements are legal.
  function automatic logic is_legal(input logic [CBITS-1:0] code);
    logic ok;
    case (code)
      CBITS'(4'b0000): ok = 1'b1;
      CBITS'(4'b0001): ok = 1'b1;
      CBITS'(4'b0010): ok = 1'b1;
      CBITS'(4'b0110): ok = 1'b1;
      CBITS'(4'b0111): ok = 1'b1;
      CBITS'(4'b1100): ok = 1'b1;
      default:         ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Arbitration: a lone request wins, a tie goes to the one not served last.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      sel = ~last;
    end else if (req1_valid) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
    if (grant) begin
      rsp_done = rsp1_ready;
    end else begin
      rsp_done = rsp0_ready;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_next = EXEC;
        end else begin
          state_next = IDLE;
        end
      end
      EXEC: state_next = RESP;
      RESP: begin
        if (rsp_done) begin
          state_next = IDLE;
        end else begin
          state_next = RESP;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, op and result registers; reset drops any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      last        <= 1'b1;
      grant       <= 1'b0;
      op_first    <= '0;
      op_second   <= '0;
      op_control  <= '0;
      rsp_result  <= '0;
      rsp_zero    <= 1'b0;
      rsp_illegal <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (any_valid) begin
            grant <= sel;
            if (sel) begin
              op_first   <= req1_first;
              op_second  <= req1_second;
              op_control <= req1_control;
            end else begin
              op_first   <= req0_first;
              op_second  <= req0_second;
              op_control <= req0_control;
            end
          end
        end
        EXEC: begin
          // The ALU holds a stale value on unknown codes, so never trust it then.
          if (is_legal(op_control)) begin
            rsp_result  <= alu_result;
            rsp_zero    <= alu_zero;
            rsp_illegal <= 1'b0;
          end else begin
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_done) begin
            last <= grant;
          end
        end
        default: begin
          grant <= 1'b0;
        end
      endcase
    end
  end

  // Handshake outputs; forced low while reset is asserted.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    if (!reset && state == IDLE && any_valid) begin
      req0_ready = ~sel;
      req1_ready = sel;
    end else if (!reset && state == RESP) begin
      rsp0_valid = ~grant;
      rsp1_valid = grant;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
    busy        = (state != IDLE);
    alu_first   = op_first;
    alu_second  = op_second;
    alu_control = op_control;
  end

endmodule
